// File: rtl/multi_phase_light_ctrl.sv
// ----------------------------------------------------------------------------
// multi_phase_light_ctrl
//
// Round-robin traffic light sequencer for NUM_PHASES approaches. Each approach
// gets a base green, optionally one sensor-driven extension, a yellow and an
// all-red clearance. A latched pedestrian request for the approach inserts a
// walk interval (followed by a second clearance) before right of way moves on.
// Interval lengths come from a small table that can be rewritten at run time.
// Timing advances only on tick_i, the 1 Hz enable from the upstream divider.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   tick_i       one-clock-wide timebase enable
//   sensor_i     vehicle present, one bit per approach (already synchronised)
//   walk_req_i   pedestrian request pulse, one bit per approach (already synchronised)
//   prog_we_i    write the interval table this cycle
//   prog_sel_i   table entry: 0 green, 1 ext, 2 yellow, 3 clear, 4 walk; 5-7 ignored
//   prog_val_i   new interval value
//   green_o      green lamp per approach
//   yellow_o     yellow lamp per approach
//   walk_o       walk lamp per approach
//   phase_o      approach currently owning right of way
//   state_o      0 START, 1 GREEN, 2 EXTEND, 3 YELLOW, 4 CLEAR, 5 WALK
//   timer_o      current countdown value
//   expired_o    tick_i && timer_o == 0
// ----------------------------------------------------------------------------
module multi_phase_light_ctrl #(
   parameter int unsigned NUM_PHASES = 4,
   parameter int unsigned TW         = 4,
   parameter int unsigned DEF_GREEN  = 6,
   parameter int unsigned DEF_EXT    = 3,
   parameter int unsigned DEF_YELLOW = 2,
   parameter int unsigned DEF_CLEAR  = 1,
   parameter int unsigned DEF_WALK   = 3,
   localparam int unsigned PW = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tick_i,
   input  logic [NUM_PHASES-1:0] sensor_i,
   input  logic [NUM_PHASES-1:0] walk_req_i,
   input  logic                  prog_we_i,
   input  logic [2:0]            prog_sel_i,
   input  logic [TW-1:0]         prog_val_i,
   output logic [NUM_PHASES-1:0] green_o,
   output logic [NUM_PHASES-1:0] yellow_o,
   output logic [NUM_PHASES-1:0] walk_o,
   output logic [PW-1:0]         phase_o,
   output logic [2:0]            state_o,
   output logic [TW-1:0]         timer_o,
   output logic                  expired_o
);

   typedef enum logic [2:0] {
      StStart  = 3'd0,
      StGreen  = 3'd1,
      StExtend = 3'd2,
      StYellow = 3'd3,
      StClear  = 3'd4,
      StWalk   = 3'd5
   } state_e;

   localparam logic [PW-1:0] LastPhase = PW'(NUM_PHASES - 1);

   // Sequencer state
   state_e                  state_q,     state_d;
   logic [PW-1:0]           phase_q,     phase_d;
   logic [TW-1:0]           timer_q,     timer_d;
   logic                    ext_used_q,  ext_used_d;
   logic                    walk_done_q, walk_done_d;
   logic [NUM_PHASES-1:0]   walk_pend_q, walk_pend_d;

   // Interval table
   logic [TW-1:0]           green_iv_q,  green_iv_d;
   logic [TW-1:0]           ext_iv_q,    ext_iv_d;
   logic [TW-1:0]           yellow_iv_q, yellow_iv_d;
   logic [TW-1:0]           clear_iv_q,  clear_iv_d;
   logic [TW-1:0]           walk_iv_q,   walk_iv_d;

   logic                    expired;
   logic [PW-1:0]           phase_inc;
   logic [TW-1:0]           load_raw;

   assign expired   = tick_i && (timer_q == '0);
   assign phase_inc = (phase_q == LastPhase) ? '0 : phase_q + PW'(1);

   // ------------------------------------------------------------------------
   // Interval table writes. The sequencer reads the _q copy, so a load on the
   // same edge as a write to that entry still sees the old value.
   // ------------------------------------------------------------------------
   always_comb begin
      green_iv_d  = green_iv_q;
      ext_iv_d    = ext_iv_q;
      yellow_iv_d = yellow_iv_q;
      clear_iv_d  = clear_iv_q;
      walk_iv_d   = walk_iv_q;
      if (prog_we_i) begin
         case (prog_sel_i)
            3'd0:    green_iv_d  = prog_val_i;
            3'd1:    ext_iv_d    = prog_val_i;
            3'd2:    yellow_iv_d = prog_val_i;
            3'd3:    clear_iv_d  = prog_val_i;
            3'd4:    walk_iv_d   = prog_val_i;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic: transitions fire only on an expiring tick, and the
   // timer is reloaded for the destination state on that same edge.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      timer_d     = timer_q;
      ext_used_d  = ext_used_q;
      walk_done_d = walk_done_q;
      walk_pend_d = walk_pend_q;
      load_raw    = '0;

      if (expired) begin
         case (state_q)
            StStart: begin
               state_d = StGreen;
               phase_d = '0;
            end
            StGreen: begin
               if (sensor_i[phase_q] && !ext_used_q) begin
                  state_d    = StExtend;
                  ext_used_d = 1'b1;
               end else begin
                  state_d = StYellow;
               end
            end
            StExtend: state_d = StYellow;
            StYellow: state_d = StClear;
            StClear: begin
               if (walk_done_q) begin
                  // Second clearance after a walk: hand over to the next approach.
                  walk_done_d = 1'b0;
                  phase_d     = phase_inc;
                  state_d     = StGreen;
               end else if (walk_pend_q[phase_q]) begin
                  state_d              = StWalk;
                  walk_pend_d[phase_q] = 1'b0;
               end else begin
                  phase_d = phase_inc;
                  state_d = StGreen;
               end
            end
            StWalk: begin
               state_d     = StClear;
               walk_done_d = 1'b1;
            end
            default: begin
               state_d = StStart;
               phase_d = '0;
            end
         endcase

         if (state_d == StGreen) begin
            ext_used_d = 1'b0;
         end

         case (state_d)
            StGreen:  load_raw = green_iv_q;
            StExtend: load_raw = ext_iv_q;
            StYellow: load_raw = yellow_iv_q;
            StClear:  load_raw = clear_iv_q;
            StWalk:   load_raw = walk_iv_q;
            default:  load_raw = clear_iv_q;
         endcase
         // A zero interval would collapse the state to a single tick of 0; run it as 1.
         timer_d = (load_raw == '0) ? TW'(1) : load_raw;
      end else if (tick_i) begin
         timer_d = timer_q - TW'(1);
      end

      // Requests are OR-ed in last so a request on the serving edge survives the clear.
      walk_pend_d = walk_pend_d | walk_req_i;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StStart;
         phase_q     <= '0;
         timer_q     <= TW'(DEF_CLEAR);
         ext_used_q  <= 1'b0;
         walk_done_q <= 1'b0;
         walk_pend_q <= '0;
         green_iv_q  <= TW'(DEF_GREEN);
         ext_iv_q    <= TW'(DEF_EXT);
         yellow_iv_q <= TW'(DEF_YELLOW);
         clear_iv_q  <= TW'(DEF_CLEAR);
         walk_iv_q   <= TW'(DEF_WALK);
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         timer_q     <= timer_d;
         ext_used_q  <= ext_used_d;
         walk_done_q <= walk_done_d;
         walk_pend_q <= walk_pend_d;
         green_iv_q  <= green_iv_d;
         ext_iv_q    <= ext_iv_d;
         yellow_iv_q <= yellow_iv_d;
         clear_iv_q  <= clear_iv_d;
         walk_iv_q   <= walk_iv_d;
      end
   end

   // ------------------------------------------------------------------------
   // Lamp decode straight from registered state and phase; only one lamp in
   // the whole intersection can be lit because phase selects a single bit.
   // ------------------------------------------------------------------------
   always_comb begin
      green_o  = '0;
      yellow_o = '0;
      walk_o   = '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (phase_q == PW'(i)) begin
            green_o[i]  = (state_q == StGreen) || (state_q == StExtend);
            yellow_o[i] = (state_q == StYellow);
            walk_o[i]   = (state_q == StWalk);
         end
      end
   end

   assign phase_o   = phase_q;
   assign state_o   = state_q;
   assign timer_o   = timer_q;
   assign expired_o = expired;

endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multi_phase_light_ctrl
//
// Directed bench for multi_phase_light_ctrl with default parameters. The
// stimulus process pushes the hand-derived sequence of light segments
// (state, phase, length in ticks, loaded timer value) into a queue. The
// monitor watches the outputs, and each time the DUT leaves a segment it pops
// the next expectation and compares the segment that just ended.
// ----------------------------------------------------------------------------
module tb_multi_phase_light_ctrl;

   localparam logic [2:0] S_START = 3'd0;
   localparam logic [2:0] S_GREEN = 3'd1;
   localparam logic [2:0] S_EXT   = 3'd2;
   localparam logic [2:0] S_YEL   = 3'd3;
   localparam logic [2:0] S_CLR   = 3'd4;
   localparam logic [2:0] S_WALK  = 3'd5;

   typedef struct {
      logic [2:0] st;
      logic [1:0] ph;
      int         ticks;
      logic [3:0] load;
   } seg_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [3:0] sensor = '0;
   logic [3:0] walk_req = '0;
   logic       prog_we = 1'b0;
   logic [2:0] prog_sel = '0;
   logic [3:0] prog_val = '0;
   logic [3:0] green_o, yellow_o, walk_o;
   logic [1:0] phase_o;
   logic [2:0] state_o;
   logic [3:0] timer_o;
   logic       expired_o;

   seg_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   seg_idx = 0;

   multi_phase_light_ctrl dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .tick_i     (tick),
      .sensor_i   (sensor),
      .walk_req_i (walk_req),
      .prog_we_i  (prog_we),
      .prog_sel_i (prog_sel),
      .prog_val_i (prog_val),
      .green_o    (green_o),
      .yellow_o   (yellow_o),
      .walk_o     (walk_o),
      .phase_o    (phase_o),
      .state_o    (state_o),
      .timer_o    (timer_o),
      .expired_o  (expired_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [1:0] ph, input int ticks,
                       input logic [3:0] load);
      seg_t s;
      s.st = st; s.ph = ph; s.ticks = ticks; s.load = load;
      exp_q.push_back(s);
   endtask

   // One tick every 4 clocks; the divider restarts while reset is held.
   initial begin
      int tcnt;
      tcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            tcnt = 0;
            tick = 1'b0;
         end else begin
            tcnt++;
            tick = (tcnt == 4);
            if (tcnt == 4) tcnt = 0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   initial begin
      logic       seg_open, t, pre_exp, changed;
      logic [3:0] pre_tim;
      logic [2:0] cur_st;
      logic [1:0] cur_ph;
      logic [3:0] ent_tim, ent_g, ent_y, ent_w, onehot;
      int         cnt;
      seg_t       e;
      seg_open = 1'b0;
      cnt = 0;
      cur_st = '0; cur_ph = '0; ent_tim = '0; ent_g = '0; ent_y = '0; ent_w = '0;
      forever begin
         @(negedge clk);
         #2;
         t       = tick;
         pre_exp = expired_o;
         pre_tim = timer_o;
         @(posedge clk);
         #1;
         if (rst) begin
            seg_open = 1'b0;
            continue;
         end
         if (!seg_open) begin
            seg_open = 1'b1;
            cnt = 0;
            cur_st = state_o; cur_ph = phase_o; ent_tim = timer_o;
            ent_g = green_o; ent_y = yellow_o; ent_w = walk_o;
            continue;
         end
         if (t) begin
            cnt++;
            if (pre_exp != (pre_tim == 4'd0))
               chk("expired_flag", int'(pre_exp), int'(pre_tim == 4'd0));
            if ($countones(green_o | yellow_o | walk_o) > 1)
               chk("lamp_exclusive", $countones(green_o | yellow_o | walk_o), 1);
         end
         changed = (state_o != cur_st) || (phase_o != cur_ph);
         if (changed != (t && pre_exp))
            chk("transition_on_expiry", int'(changed), int'(t && pre_exp));
         if (changed) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_segment_state", int'(cur_st), 7);
            end else begin
               e = exp_q.pop_front();
               onehot = 4'b0001 << e.ph;
               chk($sformatf("seg%0d_state", seg_idx), int'(cur_st), int'(e.st));
               chk($sformatf("seg%0d_phase", seg_idx), int'(cur_ph), int'(e.ph));
               chk($sformatf("seg%0d_ticks", seg_idx), cnt, e.ticks);
               chk($sformatf("seg%0d_load", seg_idx), int'(ent_tim), int'(e.load));
               chk($sformatf("seg%0d_green", seg_idx), int'(ent_g),
                   (e.st == S_GREEN || e.st == S_EXT) ? int'(onehot) : 0);
               chk($sformatf("seg%0d_yellow", seg_idx), int'(ent_y),
                   (e.st == S_YEL) ? int'(onehot) : 0);
               chk($sformatf("seg%0d_walk", seg_idx), int'(ent_w),
                   (e.st == S_WALK) ? int'(onehot) : 0);
            end
            seg_idx++;
            cnt = 0;
            cur_st = state_o; cur_ph = phase_o; ent_tim = timer_o;
            ent_g = green_o; ent_y = yellow_o; ent_w = walk_o;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic wait_for(input logic [2:0] st, input logic [1:0] ph, input int budget);
      int n;
      n = 0;
      while (1) begin
         @(posedge clk);
         #1;
         if (state_o == st && phase_o == ph) break;
         n++;
         if (n >= budget) begin
            chk($sformatf("wait_state%0d_phase%0d_timeout", st, ph), int'(state_o), int'(st));
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, int'(state_o), 0);
      chk({tag, "_phase"}, int'(phase_o), 0);
      chk({tag, "_timer"}, int'(timer_o), 1);
      chk({tag, "_lamps"}, int'({green_o, yellow_o, walk_o}), 0);
      chk({tag, "_expired"}, int'(expired_o), 0);
   endtask

   task automatic prog(input logic [2:0] sel, input logic [3:0] val);
      prog_we = 1'b1; prog_sel = sel; prog_val = val;
      @(posedge clk);
      #1;
      prog_we = 1'b0;
   endtask

   initial begin
      int n;
      // Round 1, default table: sensor[1] extension, walk on approach 2.
      push(S_START, 0, 2, 1);
      push(S_GREEN, 0, 7, 6); push(S_YEL, 0, 3, 2); push(S_CLR, 0, 2, 1);
      push(S_GREEN, 1, 7, 6); push(S_EXT, 1, 4, 3); push(S_YEL, 1, 3, 2);
      push(S_CLR, 1, 2, 1);
      push(S_GREEN, 2, 7, 6); push(S_YEL, 2, 3, 2); push(S_CLR, 2, 2, 1);
      push(S_WALK, 2, 4, 3);  push(S_CLR, 2, 2, 1);
      push(S_GREEN, 3, 7, 6); push(S_YEL, 3, 3, 2); push(S_CLR, 3, 2, 1);
      // Round 2: green reprogrammed to 2 then 0, sel 6 write ignored.
      push(S_GREEN, 0, 7, 6); push(S_YEL, 0, 3, 2); push(S_CLR, 0, 2, 1);
      push(S_GREEN, 1, 3, 2); push(S_YEL, 1, 3, 2); push(S_CLR, 1, 2, 1);
      push(S_GREEN, 2, 2, 1); push(S_YEL, 2, 3, 2); push(S_CLR, 2, 2, 1);
      push(S_WALK, 2, 4, 3);  push(S_CLR, 2, 2, 1);
      push(S_GREEN, 3, 2, 1); push(S_YEL, 3, 3, 2); push(S_CLR, 3, 2, 1);
      // Round 3: request re-latched on the walk entry edge is served again.
      push(S_GREEN, 0, 2, 1); push(S_YEL, 0, 3, 2); push(S_CLR, 0, 2, 1);
      push(S_GREEN, 1, 2, 1); push(S_YEL, 1, 3, 2); push(S_CLR, 1, 2, 1);
      push(S_GREEN, 2, 2, 1); push(S_YEL, 2, 3, 2); push(S_CLR, 2, 2, 1);

      sensor = 4'b0010;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      #1;
      rst = 1'b0;

      wait_for(S_GREEN, 0, 400);
      walk_req = 4'b0100;
      @(posedge clk);
      #1;
      walk_req = '0;

      wait_for(S_YEL, 1, 400);
      sensor = '0;

      wait_for(S_GREEN, 3, 400);
      wait_for(S_GREEN, 0, 400);
      prog(3'd0, 4'd2);
      wait_for(S_GREEN, 1, 400);
      prog(3'd0, 4'd0);
      wait_for(S_GREEN, 2, 400);
      prog(3'd6, 4'd9);
      walk_req = 4'b0100;
      @(posedge clk);
      #1;
      walk_req = '0;

      // Hold the request across the CLEAR->WALK edge for approach 2.
      wait_for(S_CLR, 2, 400);
      n = 0;
      while (timer_o != 4'd0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      walk_req = 4'b0100;
      wait_for(S_WALK, 2, 40);
      walk_req = '0;

      wait_for(S_GREEN, 3, 400);
      wait_for(S_WALK, 2, 400);
      repeat (5) @(posedge clk);
      chk("queue_drained_before_reset", exp_q.size(), 0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");

      // After reset the table is back to defaults: green load 6 again.
      push(S_START, 0, 2, 1);
      push(S_GREEN, 0, 7, 6);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      wait_for(S_YEL, 0, 400);
      repeat (2) @(posedge clk);
      chk("queue_drained_final", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
